// File: rtl/rob_wide_pkg.sv
// Shared types and constants for the wide reorder buffer.
// Entry record, index type and the opcode classes the commit stage decodes.
package rob_wide_pkg;

    localparam int unsigned ROB_DEPTH   = 4;
    localparam int unsigned ROB_ENTRIES = 2 ** ROB_DEPTH;

    typedef logic [ROB_DEPTH-1:0] rob_idx_t;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic        mispredict;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic [6:0]  opcode;
        logic [31:0] target;
    } rob_entry_t;

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/rob_bypass_read.sv
// One dispatch operand lookup port: stored entry value with same-cycle CDB bypass.
import rob_wide_pkg::*;

module rob_bypass_read #(
    parameter int unsigned CDB_SIZE = 3
) (
    input  logic                         ent_valid_i,
    input  logic                         ent_ready_i,
    input  logic [31:0]                  ent_value_i,
    input  rob_idx_t                     idx_i,
    input  logic [CDB_SIZE-1:0]          cdb_valid_i,
    input  rob_idx_t [CDB_SIZE-1:0]      cdb_rob_i,
    input  logic [CDB_SIZE-1:0][31:0]    cdb_rd_v_i,
    output logic                         ready_o,
    output logic [31:0]                  value_o
);

    logic        hit_s;
    logic [31:0] hit_v_s;

    // Scan channels in ascending order so the highest matching channel wins.
    always_comb begin
        hit_s   = 1'b0;
        hit_v_s = 32'h0;
        for (int i = 0; i < CDB_SIZE; i++) begin
            if (cdb_valid_i[i] && (cdb_rob_i[i] == idx_i)) begin
                hit_s   = 1'b1;
                hit_v_s = cdb_rd_v_i[i];
            end else begin
                hit_s   = hit_s;
            end
        end
    end

    // Live broadcast beats the stored value; an unallocated entry reads as zero.
    always_comb begin
        ready_o = ent_valid_i && (ent_ready_i || hit_s);
        if (!ent_valid_i) begin
            value_o = 32'h0;
        end else if (hit_s) begin
            value_o = hit_v_s;
        end else if (ent_ready_i) begin
            value_o = ent_value_i;
        end else begin
            value_o = 32'h0;
        end
    end

endmodule

// File: rtl/rob_wide.sv
// Superscalar reorder buffer: in-order multi-lane allocate and retire, CDB capture,
// operand lookup with bypass, and mispredict flush with redirect PC.
import rob_wide_pkg::*;

module rob_wide #(
    parameter int unsigned DISPATCH_W = 2,
    parameter int unsigned COMMIT_W   = 2,
    parameter int unsigned CDB_SIZE   = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DISPATCH_W-1:0]            alloc_valid,
    input  logic [DISPATCH_W-1:0][4:0]       alloc_rd_s,
    input  logic [DISPATCH_W-1:0][6:0]       alloc_opcode,
    input  logic [DISPATCH_W-1:0][31:0]      alloc_pc_next,
    output logic                             alloc_ready,
    output rob_idx_t [DISPATCH_W-1:0]        alloc_rob,
    input  rob_idx_t [2*DISPATCH_W-1:0]      rd_rob,
    output logic [2*DISPATCH_W-1:0]          rd_ready,
    output logic [2*DISPATCH_W-1:0][31:0]    rd_v,
    input  logic [CDB_SIZE-1:0]              cdb_valid,
    input  rob_idx_t [CDB_SIZE-1:0]          cdb_rob,
    input  logic [CDB_SIZE-1:0][31:0]        cdb_rd_v,
    input  logic [CDB_SIZE-1:0]              cdb_mispredict,
    input  logic [CDB_SIZE-1:0][31:0]        cdb_target,
    input  logic                             store_commit_ready,
    output logic [COMMIT_W-1:0]              commit_valid,
    output logic [COMMIT_W-1:0][4:0]         commit_rd_s,
    output logic [COMMIT_W-1:0][31:0]        commit_rd_v,
    output rob_idx_t [COMMIT_W-1:0]          commit_rob,
    output logic [COMMIT_W-1:0][6:0]         commit_opcode,
    output logic                             flush_o,
    output logic [31:0]                      flush_pc
);

    typedef logic [ROB_DEPTH:0] cnt_t;
    localparam cnt_t ENTRIES_CNT = cnt_t'(ROB_ENTRIES);

    rob_entry_t mem_q [ROB_ENTRIES];
    rob_entry_t mem_d [ROB_ENTRIES];
    rob_idx_t   head_q, head_d, tail_q, tail_d;
    cnt_t       count_q, count_d;
    cnt_t       n_commit_s, n_alloc_s;

    assign alloc_ready = ((ENTRIES_CNT - count_q) >= cnt_t'(DISPATCH_W)) && !flush_o;

    // Commit selection: prefix of ready entries from head, one store per group, stop after a mispredict.
    always_comb begin : commit_sel
        rob_entry_t ent;
        logic       blocked;
        logic       store_seen;
        logic       is_store;
        ent           = '0;
        blocked       = 1'b0;
        store_seen    = 1'b0;
        is_store      = 1'b0;
        commit_valid  = '0;
        commit_rd_s   = '0;
        commit_rd_v   = '0;
        commit_rob    = '0;
        commit_opcode = '0;
        flush_o       = 1'b0;
        flush_pc      = 32'h0;
        n_commit_s    = '0;
        for (int j = 0; j < COMMIT_W; j++) begin
            commit_rob[j]    = head_q + rob_idx_t'(j);
            ent              = mem_q[commit_rob[j]];
            is_store         = (ent.opcode == OP_STORE);
            commit_rd_s[j]   = ent.rd_s;
            commit_rd_v[j]   = ent.rd_v;
            commit_opcode[j] = ent.opcode;
            if (!blocked && ent.valid && ent.ready &&
                (!is_store || (store_commit_ready && !store_seen))) begin
                commit_valid[j] = 1'b1;
                n_commit_s      = n_commit_s + cnt_t'(1);
                store_seen      = store_seen | is_store;
                if (ent.mispredict && is_ctrl(ent.opcode)) begin
                    flush_o  = 1'b1;
                    flush_pc = ent.target;
                    blocked  = 1'b1;
                end else begin
                    blocked  = 1'b0;
                end
            end else begin
                blocked = 1'b1;
            end
        end
    end

    // Lane k is always offered entry tail+k.
    always_comb begin
        for (int k = 0; k < DISPATCH_W; k++) begin
            alloc_rob[k] = tail_q + rob_idx_t'(k);
        end
    end

    // Next-state: retire, allocate, capture CDB (against pre-edge valid bits), then flush override.
    always_comb begin
        mem_d     = mem_q;
        n_alloc_s = '0;
        for (int j = 0; j < COMMIT_W; j++) begin
            if (commit_valid[j]) begin
                mem_d[commit_rob[j]].valid = 1'b0;
            end else begin
                mem_d[commit_rob[j]].valid = mem_d[commit_rob[j]].valid;
            end
        end
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (alloc_ready && alloc_valid[k]) begin
                mem_d[alloc_rob[k]] = '{valid: 1'b1, ready: 1'b0, mispredict: 1'b0,
                                        rd_s: alloc_rd_s[k], rd_v: 32'h0,
                                        opcode: alloc_opcode[k], target: alloc_pc_next[k]};
                n_alloc_s = n_alloc_s + cnt_t'(1);
            end else begin
                n_alloc_s = n_alloc_s;
            end
        end
        for (int i = 0; i < CDB_SIZE; i++) begin
            if (cdb_valid[i] && mem_q[cdb_rob[i]].valid) begin
                mem_d[cdb_rob[i]].ready = 1'b1;
                mem_d[cdb_rob[i]].rd_v  = cdb_rd_v[i];
                if (cdb_mispredict[i]) begin
                    mem_d[cdb_rob[i]].mispredict = 1'b1;
                    mem_d[cdb_rob[i]].target     = cdb_target[i];
                end else begin
                    mem_d[cdb_rob[i]].mispredict = mem_d[cdb_rob[i]].mispredict;
                end
            end else begin
                n_alloc_s = n_alloc_s;
            end
        end
        head_d  = head_q + n_commit_s[ROB_DEPTH-1:0];
        tail_d  = tail_q + n_alloc_s[ROB_DEPTH-1:0];
        count_d = count_q + n_alloc_s - n_commit_s;
        if (flush_o) begin
            for (int e = 0; e < ROB_ENTRIES; e++) begin
                mem_d[e].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            count_d = count_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int e = 0; e < ROB_ENTRIES; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    for (genvar p = 0; p < 2*DISPATCH_W; p++) begin : g_rd
        rob_bypass_read #(.CDB_SIZE(CDB_SIZE)) u_rd (
            .ent_valid_i (mem_q[rd_rob[p]].valid),
            .ent_ready_i (mem_q[rd_rob[p]].ready),
            .ent_value_i (mem_q[rd_rob[p]].rd_v),
            .idx_i       (rd_rob[p]),
            .cdb_valid_i (cdb_valid),
            .cdb_rob_i   (cdb_rob),
            .cdb_rd_v_i  (cdb_rd_v),
            .ready_o     (rd_ready[p]),
            .value_o     (rd_v[p])
        );
    end

endmodule
